// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART send path.
// FSM state encoding, default sizes and a constant clog2 helper.
package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// APB write strobe/data and uart_tx start/busy handshake bundle.
// slave: the feeder; master: APB side plus transmitter (or a bench).
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              apb_wen;
  logic [DATA_W-1:0] apb_wdata;
  logic              tx_busy;
  logic              send_en;
  logic [DATA_W-1:0] send_data;

  modport slave (
    input  apb_wen,
    input  apb_wdata,
    input  tx_busy,
    output send_en,
    output send_data
  );

  modport master (
    output apb_wen,
    output apb_wdata,
    output tx_busy,
    input  send_en,
    input  send_data
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO: rdata is the head word combinationally.
// Ports: push/pop/wdata in; rdata/full/empty/level out; sync reset.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rd_en = pop & ~empty;
  // a full FIFO still accepts a word when a pop frees a slot
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers APB write strobes and feeds uart_tx one word per frame.
// Ports: sys_clk/sys_rst, link (apb_wen/wdata, tx_busy, send_en/data), fifo status, overflow, timeout.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int BUSY_TO   = 64,
  parameter int SIM_PRINT = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  uart_tx_feeder_if.slave       link,
  input  logic                  overflow_clr,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [clog2(DEPTH):0] fifo_level,
  output logic                  overflow,
  output logic                  timeout
);
  localparam int TW = (BUSY_TO > 0) ? clog2(BUSY_TO + 1) : 1;
  localparam logic [TW-1:0] TO_LAST =
    TW'((BUSY_TO > 0) ? BUSY_TO - 1 : 0);

  logic              wen_d0;
  logic              wen_d1;
  logic [DATA_W-1:0] wdata_d0;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic [TW-1:0]     to_cnt;
  logic              to_hit;
  state_t            state;
  state_t            state_nxt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wen_d0   <= 1'b0;
      wen_d1   <= 1'b0;
      wdata_d0 <= '0;
    end else begin
      wen_d0   <= link.apb_wen;
      wen_d1   <= wen_d0;
      wdata_d0 <= link.apb_wdata;
    end
  end

  // apb_wen is a level; only its rising edge queues a word
  assign push = wen_d0 & ~wen_d1;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (push),
    .pop     (pop),
    .wdata   (wdata_d0),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign to_hit = (BUSY_TO != 0) && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !link.tx_busy) begin
          pop       = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: state_nxt = ST_WAIT_START;
      ST_WAIT_START: begin
        if (link.tx_busy)  state_nxt = ST_WAIT_DONE;
        else if (to_hit)   state_nxt = ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (!link.tx_busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state          <= ST_IDLE;
      link.send_en   <= 1'b0;
      link.send_data <= '0;
      timeout        <= 1'b0;
      to_cnt         <= '0;
      overflow       <= 1'b0;
    end else begin
      state        <= state_nxt;
      link.send_en <= (state == ST_SEND);
      timeout      <= (state == ST_WAIT_START) &&
                      !link.tx_busy && to_hit;
      if (pop) link.send_data <= head;
      // held at zero outside WAIT_START, saturates inside it
      if (state != ST_WAIT_START) to_cnt <= '0;
      else if (to_cnt != '1)      to_cnt <= to_cnt + TW'(1);
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (overflow_clr)         overflow <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  if (SIM_PRINT != 0) begin : g_print
    always @(posedge sys_clk) begin
      if (!sys_rst && pop) $write("%s", head);
    end
  end
`endif

endmodule
